// File: rtl/add_sched_pkg.sv
// Shared types and constants for the round-robin adder scheduler.
// Holds the FSM state enum, default sizes and the ID-width helper.
package add_sched_pkg;

    localparam int DEF_NREQ  = 2;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        CALC,
        RESP
    } state_t;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_rr_scheduler_if.sv
// Requester and response bundle of the adder scheduler.
// Master drives requests and response-ready; slave is the scheduler.
interface add_rr_scheduler_if #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8
);
    import add_sched_pkg::*;

    localparam int IDW = idw(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_carry;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_sum,
        input  rsp_carry
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_sum,
        output rsp_carry
    );

endinterface

// File: rtl/add_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid request at or
// above the pointer, wrapping around, wins.
module rr_arbiter
    import add_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int off = 0; off < NREQ; off++) begin
            j = (int'(ptr) + off) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/add_rr_scheduler.sv
// Shares one adder between NREQ requesters with round-robin grants.
// Define ADD_SAT_EN to saturate the sum to all-ones on carry-out.
module add_rr_scheduler
    import add_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    add_rr_scheduler_if.slave bus,
    output logic busy
);

    localparam int IDW = idw(NREQ);

    state_t state;
    state_t nxt;

    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  ready;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id_q;
    logic             any;
    logic             accept;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             valid_q;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] res;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    assign accept = (state == IDLE) && any;
    assign full   = {1'b0, a_q} + {1'b0, b_q};

`ifdef ADD_SAT_EN
    assign res = full[WIDTH] ? '1 : full[WIDTH-1:0];
`else
    assign res = full[WIDTH-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt   = state;
        ready = '0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    ready = grant;
                    nxt   = LATCH;
                end
            end
            LATCH: nxt = CALC;
            CALC:  nxt = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Operands are captured on the handshake edge; the
    // requester is free to change its inputs afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= bus.req_a[int'(win)*WIDTH +: WIDTH];
                b_q  <= bus.req_b[int'(win)*WIDTH +: WIDTH];
                id_q <= win;
                ptr  <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
            end
            if (state == CALC) begin
                sum_q   <= res;
                carry_q <= full[WIDTH];
                valid_q <= 1'b1;
            end
            if (state == RESP && bus.rsp_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_carry = carry_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_add_rr_scheduler.sv
// Directed bench for add_rr_scheduler with NREQ=2, WIDTH=8.
// Build with ADD_SAT_EN defined to check the saturating variant.
module tb_add_rr_scheduler;

    logic clk;
    logic rst_n;
    logic busy;
    int   nvec;
    int   nerr;

`ifdef ADD_SAT_EN
    localparam logic [7:0] OVF_SUM = 8'hFF;
    localparam logic [7:0] MAX_SUM = 8'hFF;
`else
    localparam logic [7:0] OVF_SUM = 8'h00;
    localparam logic [7:0] MAX_SUM = 8'hFE;
`endif

    add_rr_scheduler_if #(.NREQ(2), .WIDTH(8)) bif ();

    add_rr_scheduler #(
        .NREQ  (2),
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] a,
                           input logic [7:0] b, input logic v);
        bif.req_a[i*8 +: 8] = a;
        bif.req_b[i*8 +: 8] = b;
        bif.req_valid[i]    = v;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n         = 1'b0;
        bif.req_valid = '0;
        bif.req_a     = '0;
        bif.req_b     = '0;
        bif.rsp_ready = 1'b0;
        #12;
        chk("rst_rsp_valid", 32'(bif.rsp_valid), 0);
        chk("rst_rsp_sum", 32'(bif.rsp_sum), 0);
        chk("rst_rsp_carry", 32'(bif.rsp_carry), 0);
        chk("rst_rsp_id", 32'(bif.rsp_id), 0);
        chk("rst_req_ready", 32'(bif.req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // reset while a response is pending
        set_req(0, 8'h10, 8'h20, 1'b1);
        #1;
        chk("mr_ready", 32'(bif.req_ready), 32'h1);
        tick();
        set_req(0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("mr_valid", 32'(bif.rsp_valid), 1);
        chk("mr_sum", 32'(bif.rsp_sum), 32'h30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid_rst", 32'(bif.rsp_valid), 0);
        chk("mr_busy_rst", 32'(busy), 0);
        chk("mr_sum_rst", 32'(bif.rsp_sum), 0);
        tick();
        rst_n = 1'b1;
        tick();
        set_req(0, 8'h01, 8'h01, 1'b1);
        set_req(1, 8'h02, 8'h02, 1'b1);
        #1;
        chk("mr_ptr0_grant", 32'(bif.req_ready), 32'h1);
        tick();
        set_req(0, 8'h00, 8'h00, 1'b0);
        set_req(1, 8'h00, 8'h00, 1'b0);
        bif.rsp_ready = 1'b1;
        tick();
        tick();
        chk("mr_op_sum", 32'(bif.rsp_sum), 32'h02);
        chk("mr_op_id", 32'(bif.rsp_id), 0);
        tick();
        chk("mr_op_done", 32'(bif.rsp_valid), 0);

        // single add; rsp_ready held high throughout
        set_req(0, 8'h12, 8'h34, 1'b1);
        #1;
        chk("s_ready", 32'(bif.req_ready), 32'h1);
        tick();
        set_req(0, 8'h00, 8'h00, 1'b0);
        chk("s_lat1_valid", 32'(bif.rsp_valid), 0);
        chk("s_lat1_busy", 32'(busy), 1);
        tick();
        chk("s_lat2_valid", 32'(bif.rsp_valid), 0);
        tick();
        chk("s_valid", 32'(bif.rsp_valid), 1);
        chk("s_sum", 32'(bif.rsp_sum), 32'h46);
        chk("s_carry", 32'(bif.rsp_carry), 0);
        chk("s_id", 32'(bif.rsp_id), 0);
        tick();
        chk("s_done_valid", 32'(bif.rsp_valid), 0);
        chk("s_done_busy", 32'(busy), 0);

        // overflow from requester 1
        set_req(1, 8'hFF, 8'h01, 1'b1);
        #1;
        chk("o_ready", 32'(bif.req_ready), 32'h2);
        tick();
        set_req(1, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("o_sum", 32'(bif.rsp_sum), 32'(OVF_SUM));
        chk("o_carry", 32'(bif.rsp_carry), 1);
        chk("o_id", 32'(bif.rsp_id), 1);
        tick();

        // all-ones plus all-ones
        set_req(1, 8'hFF, 8'hFF, 1'b1);
        #1;
        chk("m_ready", 32'(bif.req_ready), 32'h2);
        tick();
        set_req(1, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("m_sum", 32'(bif.rsp_sum), 32'(MAX_SUM));
        chk("m_carry", 32'(bif.rsp_carry), 1);
        tick();

        // continuous contention, pointer at 0
        set_req(0, 8'h11, 8'h22, 1'b1);
        set_req(1, 8'h40, 8'h0F, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("c_grant", 32'(bif.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            tick();
            tick();
            chk("c_valid", 32'(bif.rsp_valid), 1);
            chk("c_id", 32'(bif.rsp_id), 32'(k % 2));
            chk("c_sum", 32'(bif.rsp_sum), (k % 2 == 0) ? 32'h33 : 32'h4F);
            tick();
        end
        set_req(0, 8'h00, 8'h00, 1'b0);
        set_req(1, 8'h00, 8'h00, 1'b0);

        // backpressure with a waiting request
        bif.rsp_ready = 1'b0;
        set_req(0, 8'h01, 8'h02, 1'b1);
        #1;
        chk("b_ready", 32'(bif.req_ready), 32'h1);
        tick();
        set_req(0, 8'h00, 8'h00, 1'b0);
        set_req(1, 8'h03, 8'h04, 1'b1);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("b_hold_valid", 32'(bif.rsp_valid), 1);
            chk("b_hold_sum", 32'(bif.rsp_sum), 32'h03);
            chk("b_hold_id", 32'(bif.rsp_id), 0);
            chk("b_hold_rdy", 32'(bif.req_ready), 0);
            tick();
        end
        bif.rsp_ready = 1'b1;
        tick();
        bif.rsp_ready = 1'b0;
        chk("b_taken", 32'(bif.rsp_valid), 0);
        chk("b_wait_grant", 32'(bif.req_ready), 32'h2);
        tick();
        set_req(1, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("b2_sum", 32'(bif.rsp_sum), 32'h07);
        chk("b2_id", 32'(bif.rsp_id), 1);
        bif.rsp_ready = 1'b1;
        tick();

        // request from 1 withdrawn while busy
        set_req(0, 8'h20, 8'h01, 1'b1);
        #1;
        chk("w_ready", 32'(bif.req_ready), 32'h1);
        tick();
        set_req(0, 8'h00, 8'h00, 1'b0);
        set_req(1, 8'h55, 8'h55, 1'b1);
        #1;
        chk("w_busy_rdy", 32'(bif.req_ready), 0);
        tick();
        set_req(1, 8'h00, 8'h00, 1'b0);
        tick();
        chk("w_sum", 32'(bif.rsp_sum), 32'h21);
        chk("w_id", 32'(bif.rsp_id), 0);
        tick();
        chk("w_idle_rdy", 32'(bif.req_ready), 0);
        chk("w_idle_busy", 32'(busy), 0);
        tick();
        chk("w_no_grant", 32'(busy), 0);
        set_req(0, 8'h01, 8'h00, 1'b1);
        set_req(1, 8'h02, 8'h00, 1'b1);
        #1;
        chk("w_ptr_kept", 32'(bif.req_ready), 32'h2);
        tick();
        set_req(0, 8'h00, 8'h00, 1'b0);
        set_req(1, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        chk("w_last_id", 32'(bif.rsp_id), 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
